// File: rtl/digital_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: bus map, segment codes
// and the hex-to-segment decode used by the digit pipeline.
package digital_scan_driver_pkg;

  localparam logic [31:0] DISPLAY_ADDRESS = 32'h40000018;
  localparam logic [31:0] CTRL_ADDRESS    = 32'h4000001C;

  // Anodes and segments are active-low, so all-ones is a dark display.
  localparam logic [11:0] DIG_OFF = 12'hFFF;

  // Active-high {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = SEG_0;
      4'h1: hex7 = SEG_1;
      4'h2: hex7 = SEG_2;
      4'h3: hex7 = SEG_3;
      4'h4: hex7 = SEG_4;
      4'h5: hex7 = SEG_5;
      4'h6: hex7 = SEG_6;
      4'h7: hex7 = SEG_7;
      4'h8: hex7 = SEG_8;
      4'h9: hex7 = SEG_9;
      4'hA: hex7 = SEG_A;
      4'hB: hex7 = SEG_B;
      4'hC: hex7 = SEG_C;
      4'hD: hex7 = SEG_D;
      4'hE: hex7 = SEG_E;
      default: hex7 = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/digital_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-high seven-segment decode.
module hex_to_seg7
  import digital_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex7(i_nib);

endmodule

// File: rtl/digital_scan_driver.sv
// Memory-mapped 4-digit seven-segment scan controller with staged registers
// that only reach the display at frame boundaries while scanning.
module digital_scan_driver
  import digital_scan_driver_pkg::*;
#(
  parameter logic [31:0] CLKS_PER_DIGIT = 32'd10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_control_read,
  input  logic        i_control_write,
  input  logic [31:0] i_control_write_data,
  output logic [31:0] o_control_read_data,
  output logic [11:0] o_digital,
  output logic        o_frame_done
);

  localparam int CW = $clog2(CLKS_PER_DIGIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_DIGIT - 32'd1);

  logic [15:0]   r_stg_val, r_act_val;
  logic [3:0]    r_stg_dp, r_act_dp;
  logic [3:0]    r_stg_blank, r_act_blank;
  logic          r_en;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [11:0]   r_digital;
  logic          r_frame_done;

  logic        w_wr_disp, w_wr_ctrl, w_tick, w_wrap;
  logic [3:0]  w_nib;
  logic [6:0]  w_seg;
  logic [31:0] w_rd_data;
  logic        w_unused_wdata;

  assign w_wr_disp = i_control_write && (i_address == DISPLAY_ADDRESS);
  assign w_wr_ctrl = i_control_write && (i_address == CTRL_ADDRESS);
  assign w_tick    = (r_cnt == CNT_MAX);
  assign w_wrap    = r_en && w_tick && (r_idx == 2'd3);
  assign w_nib     = r_act_val[{r_idx, 2'b00} +: 4];
  assign w_unused_wdata = ^i_control_write_data[31:16];

  hex_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_val    <= '0;
      r_stg_dp     <= '0;
      r_stg_blank  <= '0;
      r_en         <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_digital    <= DIG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wr_disp) r_stg_val <= i_control_write_data[15:0];
      if (w_wr_ctrl) {r_stg_blank, r_stg_dp, r_en} <= i_control_write_data[8:0];

      // Staged copy uses pre-edge contents, so a write on the wrap edge waits a frame.
      if (!r_en || w_wrap) begin
        r_act_val   <= r_stg_val;
        r_act_dp    <= r_stg_dp;
        r_act_blank <= r_stg_blank;
      end

      if (!r_en) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (w_tick) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_frame_done <= w_wrap;

      if (!r_en || r_act_blank[r_idx])
        r_digital <= DIG_OFF;
      else
        r_digital <= {~(4'b0001 << r_idx), ~{r_act_dp[r_idx], w_seg}};
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (!reset && i_control_read) begin
      if (i_address == DISPLAY_ADDRESS)
        w_rd_data = {16'b0, r_stg_val};
      else if (i_address == CTRL_ADDRESS)
        w_rd_data = {23'b0, r_stg_blank, r_stg_dp, r_en};
    end
  end

  assign o_control_read_data = w_rd_data;
  assign o_digital           = r_digital;
  assign o_frame_done        = r_frame_done;

endmodule
